// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the coprocessor instruction sequencer: opcodes, instruction fields,
// FSM state encoding and small decode helpers.
package instr_sequencer_pkg;

  localparam int unsigned INSTR_W = 22;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;
  localparam logic [3:0] OP_WRMAT = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_TRANS = 4'd6;
  localparam logic [3:0] OP_OPP   = 4'd7;
  localparam logic [3:0] OP_SMUL  = 4'd8;
  localparam logic [3:0] OP_DET2  = 4'd9;
  localparam logic [3:0] OP_DET3  = 4'd10;
  localparam logic [3:0] OP_DET4  = 4'd11;
  localparam logic [3:0] OP_DET5  = 4'd12;

  // {N0[21:20], N1[19:12], ID[11:10], LIN[9:7], COL[6:4], OP[3:0]}
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned COL_LSB = 4;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned LIN_LSB = 7;
  localparam int unsigned LIN_W   = 3;
  localparam int unsigned ID_LSB  = 10;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned N1_LSB  = 12;
  localparam int unsigned N1_W    = 8;
  localparam int unsigned N0_LSB  = 20;
  localparam int unsigned N0_W    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRomWait,
    StDecode,
    StIssue,
    StExec,
    StStepWait,
    StHalt
  } seq_state_e;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_DET5;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Completion watchdog: counts enabled cycles since the last clear and flags the last allowed one.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  // TIMEOUT of 0 disables expiry entirely.
  assign o_expire = (TIMEOUT != 0) && i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetches instructions from a synchronous program ROM and hands them to the matrix coprocessor,
// one at a time, in free-run or single-step mode.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PROG_LEN = 30,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOOP     = 0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_step_mode,
  input  logic               i_step,
  output logic [AW-1:0]      o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic [INSTR_W-1:0] o_cop_instr,
  output logic               o_cop_valid,
  input  logic               i_cop_ready,
  input  logic               i_cop_done,
  output logic [AW-1:0]      o_pc,
  output logic               o_busy,
  output logic               o_halted,
  output logic               o_error
);

  localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

  seq_state_e         r_state, w_state_d;
  logic [AW-1:0]      r_pc, w_pc_d;
  logic [INSTR_W-1:0] r_instr, w_instr_d;
  logic               r_valid, w_valid_d;
  logic               r_error, w_error_d;
  logic               w_wd_clear, w_wd_en, w_wd_expire;

  assign w_wd_en    = (r_state == StExec);
  assign w_wd_clear = (r_state != StExec);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_valid <= w_valid_d;
      r_error <= w_error_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_valid_d = r_valid;
    w_error_d = r_error;
    if (i_abort) begin
      w_state_d = StIdle;
      w_valid_d = 1'b0;
      w_error_d = 1'b0;
    end else begin
      case (r_state)
        StIdle, StHalt: begin
          if (i_start) begin
            w_pc_d    = '0;
            w_error_d = 1'b0;
            w_state_d = StFetch;
          end
        end
        StFetch:   w_state_d = StRomWait;
        StRomWait: w_state_d = StDecode;
        StDecode: begin
          w_instr_d = i_rom_data;
          if (instr_op(i_rom_data) == OP_HALT) begin
            w_state_d = StHalt;
          end else if (op_illegal(instr_op(i_rom_data))) begin
            w_error_d = 1'b1;
            w_state_d = StHalt;
          end else begin
            w_valid_d = 1'b1;
            w_state_d = StIssue;
          end
        end
        StIssue: begin
          if (i_cop_ready) begin
            w_valid_d = 1'b0;
            w_state_d = StExec;
          end
        end
        StExec: begin
          // A done arriving on the expiry cycle still counts as completion.
          if (i_cop_done) begin
            w_state_d = i_step_mode ? StStepWait : StFetch;
            if (r_pc == LAST_PC) begin
              if (LOOP != 0) begin
                w_pc_d = '0;
              end else begin
                w_state_d = StHalt;
              end
            end else begin
              w_pc_d = r_pc + AW'(1);
            end
          end else if (w_wd_expire) begin
            w_error_d = 1'b1;
            w_state_d = StHalt;
          end
        end
        StStepWait: begin
          if (i_step) begin
            w_state_d = StFetch;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign o_rom_addr  = r_pc;
  assign o_pc        = r_pc;
  assign o_cop_instr = r_instr;
  assign o_cop_valid = r_valid;
  assign o_error     = r_error;
  assign o_halted    = (r_state == StHalt);
  assign o_busy      = (r_state != StIdle) && (r_state != StHalt);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ROM model, auto-responding coprocessor and hand-computed
// expectations for run, step, stall, trap, watchdog, loop, abort and reset behaviour.
module tb_instr_sequencer;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [21:0]   rom_data = '0;
  logic [21:0]   cop_instr;
  logic          cop_valid;
  logic          cop_ready = 1'b1;
  logic          cop_done = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          error;

  int n_checks = 0;
  int n_fail = 0;

  logic [21:0] rom [8];
  logic [21:0] issue_q [$];
  int          pc_q [$];
  logic        hs_flag = 1'b0;
  logic        auto_done = 1'b1;
  int          done_delay = 3;
  int          done_cnt = 0;

  instr_sequencer #(
    .PROG_LEN (4),
    .AW       (AW),
    .LOOP     (1),
    .TIMEOUT  (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_step_mode (step_mode),
    .i_step      (step),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_cop_instr (cop_instr),
    .o_cop_valid (cop_valid),
    .i_cop_ready (cop_ready),
    .i_cop_done  (cop_done),
    .o_pc        (pc),
    .o_busy      (busy),
    .o_halted    (halted),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    hs_flag  <= cop_valid & cop_ready;
    if (cop_valid && cop_ready) begin
      issue_q.push_back(cop_instr);
      pc_q.push_back(int'(pc));
    end
  end

  // Coprocessor model: done is sampled done_delay edges after the accepting edge.
  always @(negedge clk) begin
    cop_done = 1'b0;
    if (hs_flag && auto_done) done_cnt = done_delay;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) cop_done = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_halt(input string tag, output int n);
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, halted, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cop_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, cop_valid, 1);
  endtask

  function automatic logic [21:0] mk(input logic [3:0] op, input logic [7:0] n1);
    return {2'd1, n1, 2'd2, 3'd5, 3'd6, op};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int stable;
    int p;
    int exp_pc [6] = '{0, 1, 2, 3, 0, 1};
    logic [21:0] w0, w1;

    for (int i = 0; i < 8; i++) rom[i] = '0;

    // Reset state
    @(negedge clk);
    check_eq("rst_addr", rom_addr, 0);
    check_eq("rst_instr", cop_instr, 0);
    check_eq("rst_valid", cop_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_pc", pc, 0);
    rst = 1'b0;
    tick(2);

    // 1: free run ADD, SUB, HALT
    w0 = mk(4'd3, 8'h11);
    w1 = mk(4'd4, 8'h22);
    rom[0] = w0; rom[1] = w1; rom[2] = mk(4'd0, 8'h33);
    issue_q.delete();
    pulse_start();
    wait_halt("t1_halt", n);
    check_eq("t1_cycles", n, 17);
    check_eq("t1_issues", issue_q.size(), 2);
    check_eq("t1_instr0", issue_q[0], w0);
    check_eq("t1_instr1", issue_q[1], w1);
    check_eq("t1_pc", pc, 2);
    check_eq("t1_error", error, 0);
    check_eq("t1_busy", busy, 0);

    // 2: step mode; a step during FETCH is dropped
    rom[0] = mk(4'd3, 8'h01); rom[1] = mk(4'd5, 8'h02);
    rom[2] = mk(4'd8, 8'h03); rom[3] = mk(4'd0, 8'h04);
    step_mode = 1'b1;
    issue_q.delete();
    pulse_start();
    pulse_step();
    tick(12);
    check_eq("t2_issues_a", issue_q.size(), 1);
    check_eq("t2_valid_a", cop_valid, 0);
    check_eq("t2_busy_a", busy, 1);
    check_eq("t2_pc_a", pc, 1);
    pulse_step();
    tick(12);
    check_eq("t2_issues_b", issue_q.size(), 2);
    check_eq("t2_pc_b", pc, 2);
    pulse_step();
    tick(12);
    check_eq("t2_issues_c", issue_q.size(), 3);
    check_eq("t2_pc_c", pc, 3);
    check_eq("t2_valid_c", cop_valid, 0);
    pulse_step();
    wait_halt("t2_halt", n);
    check_eq("t2_issues_d", issue_q.size(), 3);
    step_mode = 1'b0;

    // 3: stalled handshake keeps valid and instr stable
    rom[0] = mk(4'd6, 8'h5A); rom[1] = mk(4'd0, 8'h00);
    cop_ready = 1'b0;
    issue_q.delete();
    pulse_start();
    wait_valid("t3_valid");
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (cop_valid === 1'b1 && cop_instr === rom[0]) stable++;
      @(negedge clk);
    end
    check_eq("t3_stable", stable, 10);
    check_eq("t3_no_hs", issue_q.size(), 0);
    cop_ready = 1'b1;
    wait_halt("t3_halt", n);
    check_eq("t3_issues", issue_q.size(), 1);

    // 4: illegal opcode trap at pc 1, then start clears error
    rom[0] = mk(4'd3, 8'h10); rom[1] = mk(4'hE, 8'h20);
    issue_q.delete();
    pulse_start();
    wait_halt("t4_halt", n);
    check_eq("t4_error", error, 1);
    check_eq("t4_pc", pc, 1);
    check_eq("t4_issues", issue_q.size(), 1);
    pulse_start();
    check_eq("t4_start_clr", error, 0);
    wait_halt("t4_halt2", n);

    // 5: watchdog expiry on the 8th EXEC cycle, then done on that same cycle
    rom[0] = mk(4'd7, 8'h77); rom[1] = mk(4'd0, 8'h00);
    auto_done = 1'b0;
    pulse_start();
    wait_valid("t5_valid");
    tick(8);
    check_eq("t5_pre_err", error, 0);
    check_eq("t5_pre_busy", busy, 1);
    tick(1);
    check_eq("t5_err", error, 1);
    check_eq("t5_halt", halted, 1);
    check_eq("t5_pc", pc, 0);
    auto_done = 1'b1;
    done_delay = 8;
    pulse_start();
    wait_valid("t5_valid2");
    tick(9);
    check_eq("t5_race_err", error, 0);
    check_eq("t5_race_halt", halted, 0);
    check_eq("t5_race_pc", pc, 1);
    wait_halt("t5_halt2", n);
    check_eq("t5_end_err", error, 0);

    // 6: looping program, abort in ISSUE, reset in EXEC
    rom[0] = mk(4'd1, 8'h01); rom[1] = mk(4'd2, 8'h02);
    rom[2] = mk(4'd9, 8'h03); rom[3] = mk(4'd12, 8'h04);
    done_delay = 1;
    issue_q.delete();
    pc_q.delete();
    pulse_start();
    n = 0;
    while (pc_q.size() < 6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) check_eq($sformatf("t6_pc%0d", i), pc_q[i], exp_pc[i]);
    check_eq("t6_det5", issue_q[3][3:0], 12);
    cop_ready = 1'b0;
    wait_valid("t6_valid");
    p = int'(pc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t6_ab_valid", cop_valid, 0);
    check_eq("t6_ab_busy", busy, 0);
    check_eq("t6_ab_halt", halted, 0);
    check_eq("t6_ab_pc", pc, p);
    cop_ready = 1'b1;
    auto_done = 1'b0;
    pulse_start();
    wait_valid("t6_valid2");
    @(negedge clk);
    check_eq("t6_exec_busy", busy, 1);
    check_eq("t6_exec_instr", cop_instr, rom[0]);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_instr", cop_instr, 0);
    check_eq("t6_rst_pc", pc, 0);
    check_eq("t6_rst_addr", rom_addr, 0);
    check_eq("t6_rst_valid", cop_valid, 0);
    check_eq("t6_rst_flags", {halted, error}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
